// File: rtl/usb_crc_pkg.sv
// Shared types, polynomials and CRC step helpers for the USB transmit CRC path.
// The self-check build option CRC_SELF_CHECK_EN uses crc_residual_ok.
package usb_crc_pkg;

    typedef enum logic {CRC5 = 1'b0, CRC16 = 1'b1} crc_sel_t;

    typedef enum logic [1:0] {IDLE, DATA, CRC, DONE} state_t;

    localparam logic [4:0]  CRC5_POLY      = 5'h05;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // One serial LFSR step; in CRC5 mode only bits [4:0] carry state.
    function automatic logic [15:0] crc_next(input logic [15:0] rem,
                                             input logic        in_bit,
                                             input crc_sel_t    mode);
        logic        fb;
        logic [15:0] nxt;
        if (mode == CRC16) begin
            fb  = in_bit ^ rem[15];
            nxt = {rem[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end else begin
            fb  = in_bit ^ rem[4];
            nxt = {11'd0, rem[3:0], 1'b0} ^ {11'd0, (fb ? CRC5_POLY : 5'h00)};
        end
        return nxt;
    endfunction

    // Complemented remainder, left-aligned so bit 15 is always the first bit sent.
    function automatic logic [15:0] crc_tx_word(input logic [15:0] rem,
                                                input crc_sel_t    mode);
        if (mode == CRC16)
            return ~rem;
        return {~rem[4:0], 11'd0};
    endfunction

    function automatic logic crc_residual_ok(input logic [15:0] rem,
                                             input crc_sel_t    mode);
        if (mode == CRC16)
            return rem == CRC16_RESIDUAL;
        return rem[4:0] == CRC5_RESIDUAL;
    endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// Serial USB CRC LFSR; mode picks the CRC5 or CRC16 tap set.
// Preset loads all ones; the register only moves when step is high.
module usb_crc_lfsr
    import usb_crc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        preset,
    input  logic        step,
    input  logic        in_bit,
    input  crc_sel_t    mode,
    output logic [15:0] remainder
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remainder <= 16'hFFFF;
        end else if (preset) begin
            remainder <= 16'hFFFF;
        end else if (step) begin
            remainder <= crc_next(remainder, in_bit, mode);
        end
    end

endmodule

// File: rtl/usb_crc_tx_sequencer.sv
// Transmit-side USB CRC sequencer: serialises a latched field LSB-first, then the
// complemented CRC5/CRC16 MSB-first. Optional checker behind CRC_SELF_CHECK_EN.
module usb_crc_tx_sequencer
    import usb_crc_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              crc_sel,
    input  logic [DATA_W-1:0] data,
    input  logic [LEN_W-1:0]  data_len,
    output logic              busy,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              done
`ifdef CRC_SELF_CHECK_EN
    ,
    output logic              crc_err
`endif
);

    state_t              state;
    state_t              state_nxt;
    crc_sel_t            mode_q;
    logic [DATA_W-1:0]   shift_reg;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    bit_cnt;
    logic [15:0]         crc_shift;
    logic [4:0]          crc_cnt;
    logic [15:0]         remainder;
    logic                accept;
    logic                xfer;
    logic                data_xfer;
    logic                crc_xfer;
    logic                last_data;
    logic                last_crc;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(DATA_W))
            return LEN_W'(DATA_W);
        return len;
    endfunction

    // Transfer is derived from state rather than bit_valid to keep the FSM loop-free.
    assign accept    = (state == IDLE) && start;
    assign data_xfer = (state == DATA) && bit_ready;
    assign crc_xfer  = (state == CRC) && bit_ready;
    assign xfer      = data_xfer || crc_xfer;
    assign last_data = (bit_cnt == len_q - LEN_W'(1));
    assign last_crc  = (crc_cnt == ((mode_q == CRC16) ? 5'd15 : 5'd4));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (data_len != '0) ? DATA : CRC;
            end
            DATA: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_out   = shift_reg[0];
                if (bit_ready && last_data)
                    state_nxt = CRC;
            end
            CRC: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_out   = crc_shift[15];
                if (bit_ready && last_crc)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mode_q  <= CRC5;
            len_q   <= '0;
            bit_cnt <= '0;
            crc_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mode_q  <= crc_sel_t'(crc_sel);
                len_q   <= clamp_len(data_len);
                bit_cnt <= '0;
                crc_cnt <= '0;
            end else if (data_xfer) begin
                bit_cnt <= bit_cnt + LEN_W'(1);
            end else if (crc_xfer) begin
                crc_cnt <= crc_cnt + 5'd1;
            end
        end
    end

    // Payload and CRC shifters carry data only; state gates their visibility on bit_out.
    always_ff @(posedge clock) begin
        if (accept) begin
            shift_reg <= data;
            crc_shift <= 16'h0000;
        end else if (data_xfer) begin
            shift_reg <= shift_reg >> 1;
            if (last_data)
                crc_shift <= crc_tx_word(crc_next(remainder, shift_reg[0], mode_q), mode_q);
        end else if (crc_xfer) begin
            crc_shift <= {crc_shift[14:0], 1'b0};
        end
    end

    usb_crc_lfsr u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .preset    (accept),
        .step      (data_xfer),
        .in_bit    (shift_reg[0]),
        .mode      (mode_q),
        .remainder (remainder)
    );

`ifdef CRC_SELF_CHECK_EN
    logic [15:0] chk_remainder;

    // Checker sees every transmitted bit, CRC included, so a clean packet leaves the residual.
    usb_crc_lfsr u_chk_lfsr (
        .clock     (clock),
        .reset     (reset),
        .preset    (accept),
        .step      (xfer),
        .in_bit    (bit_out),
        .mode      (mode_q),
        .remainder (chk_remainder)
    );

    assign crc_err = done && !crc_residual_ok(chk_remainder, mode_q);
`endif

endmodule
